// File: rtl/regbank_pkg.sv
// Shared opcode constants and sequencer state encoding for regbank_seq.
package regbank_pkg;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_AND = 2'd2;
  localparam logic [1:0] OP_LDI = 2'd3;

  // One-hot so every port decode is a single flop bit, free of decode glitches.
  typedef enum logic [3:0] {
    IDLE = 4'b0001,
    READ = 4'b0010,
    EXEC = 4'b0100,
    WB   = 4'b1000
  } state_e;

endpackage

// File: rtl/regbank_alu.sv
// Combinational ALU for regbank_seq: ADD/SUB/AND modulo 2**WIDTH with carry/borrow out.
module regbank_alu
  import regbank_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             carry
);

  logic [WIDTH:0] sum_s;
  logic [WIDTH:0] diff_s;

  assign sum_s  = {1'b0, a} + {1'b0, b};
  // Top bit of the widened difference is the unsigned borrow (a < b).
  assign diff_s = {1'b0, a} - {1'b0, b};

  // Operation select; LDI never reaches the ALU and yields zero.
  always_comb begin
    y     = {WIDTH{1'b0}};
    carry = 1'b0;
    case (op)
      OP_ADD: begin
        y     = sum_s[WIDTH-1:0];
        carry = sum_s[WIDTH];
      end
      OP_SUB: begin
        y     = diff_s[WIDTH-1:0];
        carry = diff_s[WIDTH];
      end
      OP_AND: begin
        y     = a & b;
        carry = 1'b0;
      end
      default: begin
        y     = {WIDTH{1'b0}};
        carry = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/regbank_seq.sv
// Register-bank sequencer: accept one instruction, read operands, execute, write back.
// Optional Z/C flag outputs are built when REGBANK_SEQ_FLAGS_EN is defined.
module regbank_seq
  import regbank_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [1:0]       instr_op,
  input  logic [AW-1:0]    instr_dr,
  input  logic [AW-1:0]    instr_sr1,
  input  logic [AW-1:0]    instr_sr2,
  input  logic [WIDTH-1:0] instr_imm,
  output logic [AW-1:0]    rb_sr1,
  output logic [AW-1:0]    rb_sr2,
  output logic [AW-1:0]    rb_dr,
  output logic             rb_write,
  output logic [WIDTH-1:0] rb_wrData,
  input  logic [WIDTH-1:0] rb_rdData1,
  input  logic [WIDTH-1:0] rb_rdData2,
  output logic             done,
  output logic [WIDTH-1:0] result
`ifdef REGBANK_SEQ_FLAGS_EN
  ,
  output logic             flag_z,
  output logic             flag_c
`endif
);

  state_e           state_r;
  state_e           state_next_s;
  logic [1:0]       op_r;
  logic [AW-1:0]    dr_r;
  logic [AW-1:0]    sr1_r;
  logic [AW-1:0]    sr2_r;
  logic [WIDTH-1:0] opa_r;
  logic [WIDTH-1:0] opb_r;
  logic [WIDTH-1:0] wb_data_r;
  logic             carry_r;
  logic [WIDTH-1:0] result_r;
  logic [WIDTH-1:0] alu_y_s;
  logic             alu_c_s;
  logic             ready_s;
  logic             wb_s;

  regbank_alu #(.WIDTH(WIDTH)) u_alu (
    .op    (op_r),
    .a     (opa_r),
    .b     (opb_r),
    .y     (alu_y_s),
    .carry (alu_c_s)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_next_s;
  end

  // Next-state logic; LDI skips the operand read and execute steps.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (instr_valid) state_next_s = (instr_op == OP_LDI) ? WB : READ;
        else             state_next_s = IDLE;
      end
      READ:    state_next_s = EXEC;
      EXEC:    state_next_s = WB;
      WB:      state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Output decode straight from the one-hot state flops.
  always_comb begin
    ready_s = 1'b0;
    wb_s    = 1'b0;
    case (state_r)
      IDLE:    ready_s = 1'b1;
      WB:      wb_s    = 1'b1;
      default: begin
        ready_s = 1'b0;
        wb_s    = 1'b0;
      end
    endcase
  end

  // Instruction capture, operand latch, execute result and write-back tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r      <= 2'd0;
      dr_r      <= {AW{1'b0}};
      sr1_r     <= {AW{1'b0}};
      sr2_r     <= {AW{1'b0}};
      opa_r     <= {WIDTH{1'b0}};
      opb_r     <= {WIDTH{1'b0}};
      wb_data_r <= {WIDTH{1'b0}};
      carry_r   <= 1'b0;
      result_r  <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (instr_valid) begin
            op_r  <= instr_op;
            dr_r  <= instr_dr;
            sr1_r <= instr_sr1;
            sr2_r <= instr_sr2;
            // The immediate goes straight to the write-back register.
            if (instr_op == OP_LDI) wb_data_r <= instr_imm;
          end
        end
        READ: begin
          opa_r <= rb_rdData1;
          opb_r <= rb_rdData2;
        end
        EXEC: begin
          wb_data_r <= alu_y_s;
          carry_r   <= alu_c_s;
        end
        WB:      result_r <= wb_data_r;
        default: result_r <= result_r;
      endcase
    end
  end

`ifdef REGBANK_SEQ_FLAGS_EN
  logic flag_z_r;
  logic flag_c_r;

  // Flags follow ALU write-backs only; LDI leaves them untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_z_r <= 1'b0;
      flag_c_r <= 1'b0;
    end else if ((state_r == WB) && (op_r != OP_LDI)) begin
      flag_z_r <= (wb_data_r == {WIDTH{1'b0}});
      flag_c_r <= carry_r;
    end
  end

  assign flag_z = flag_z_r;
  assign flag_c = flag_c_r;
`endif

  assign instr_ready = ready_s;
  assign rb_sr1      = sr1_r;
  assign rb_sr2      = sr2_r;
  assign rb_dr       = dr_r;
  assign rb_write    = wb_s;
  assign rb_wrData   = wb_data_r;
  assign done        = wb_s;
  assign result      = result_r;

endmodule

// File: tb/tb_regbank_seq.sv
// Directed bench for regbank_seq with a behavioural 4 x 32 register bank attached.
module tb_regbank_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [1:0]  instr_op = 2'd0;
  logic [1:0]  instr_dr = 2'd0;
  logic [1:0]  instr_sr1 = 2'd0;
  logic [1:0]  instr_sr2 = 2'd0;
  logic [31:0] instr_imm = 32'd0;
  logic [1:0]  rb_sr1, rb_sr2, rb_dr;
  logic        rb_write;
  logic [31:0] rb_wrData, rb_rdData1, rb_rdData2;
  logic        done;
  logic [31:0] result;
`ifdef REGBANK_SEQ_FLAGS_EN
  logic        flag_z, flag_c;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;
  int done_seen;
  int ready_seen;

  logic [31:0] mem [4] = '{32'hDEAD_0000, 32'hDEAD_0001, 32'hDEAD_0002, 32'hDEAD_0003};

  regbank_seq dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
    .instr_dr(instr_dr), .instr_sr1(instr_sr1), .instr_sr2(instr_sr2), .instr_imm(instr_imm),
    .rb_sr1(rb_sr1), .rb_sr2(rb_sr2), .rb_dr(rb_dr), .rb_write(rb_write),
    .rb_wrData(rb_wrData), .rb_rdData1(rb_rdData1), .rb_rdData2(rb_rdData2),
    .done(done), .result(result)
`ifdef REGBANK_SEQ_FLAGS_EN
    , .flag_z(flag_z), .flag_c(flag_c)
`endif
  );

  always #5 clk = ~clk;

  assign rb_rdData1 = mem[rb_sr1];
  assign rb_rdData2 = mem[rb_sr2];

  always @(posedge clk) begin
    if (rb_write) mem[rb_dr] <= rb_wrData;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic issue(input logic [1:0] op, input logic [1:0] dr, input logic [1:0] s1,
                       input logic [1:0] s2, input logic [31:0] imm);
    instr_valid = 1'b1;
    instr_op    = op;
    instr_dr    = dr;
    instr_sr1   = s1;
    instr_sr2   = s2;
    instr_imm   = imm;
  endtask

  // Issue an ALU op from IDLE and check the write-back three edges after accept.
  task automatic alu_op(input string tag, input logic [1:0] op, input logic [1:0] dr,
                        input logic [1:0] s1, input logic [1:0] s2, input logic [31:0] exp);
    issue(op, dr, s1, s2, 32'd0);
    tick;
    instr_valid = 1'b0;
    chk({tag, "_read_wr"}, 32'(rb_write), 32'd0);
    tick;
    tick;
    chk({tag, "_wr"}, 32'(rb_write), 32'd1);
    chk({tag, "_dr"}, 32'(rb_dr), 32'(dr));
    chk({tag, "_data"}, rb_wrData, exp);
    chk({tag, "_done"}, 32'(done), 32'd1);
    tick;
    chk({tag, "_result"}, result, exp);
    chk({tag, "_idle_wr"}, 32'(rb_write), 32'd0);
  endtask

  task automatic ldi(input string tag, input logic [1:0] dr, input logic [31:0] imm);
    issue(2'd3, dr, 2'd0, 2'd0, imm);
    tick;
    instr_valid = 1'b0;
    chk({tag, "_wr"}, 32'(rb_write), 32'd1);
    chk({tag, "_dr"}, 32'(rb_dr), 32'(dr));
    chk({tag, "_data"}, rb_wrData, imm);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_ready"}, 32'(instr_ready), 32'd0);
    tick;
    chk({tag, "_result"}, result, imm);
    chk({tag, "_done_low"}, 32'(done), 32'd0);
  endtask

  initial begin
    #2 rst = 1'b1;
    #1;
    chk("rst_ready", 32'(instr_ready), 32'd1);
    chk("rst_write", 32'(rb_write), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_wrdata", rb_wrData, 32'd0);
    chk("rst_dr", 32'(rb_dr), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick;
    chk("post_rst_ready", 32'(instr_ready), 32'd1);
    chk("post_rst_write", 32'(rb_write), 32'd0);

    ldi("ldi_r1", 2'd1, 32'h0000_0005);
    ldi("ldi_r2", 2'd2, 32'h0000_0003);

    // ADD R3,R1,R2 with an LDI already waiting behind it.
    issue(2'd0, 2'd3, 2'd1, 2'd2, 32'd0);
    tick;
    chk("add_sr1", 32'(rb_sr1), 32'd1);
    chk("add_sr2", 32'(rb_sr2), 32'd2);
    chk("add_ready_read", 32'(instr_ready), 32'd0);
    issue(2'd3, 2'd0, 2'd0, 2'd0, 32'h0000_0077);
    tick;
    chk("add_exec_wr", 32'(rb_write), 32'd0);
    chk("add_exec_ready", 32'(instr_ready), 32'd0);
    tick;
    chk("add_wr", 32'(rb_write), 32'd1);
    chk("add_dr", 32'(rb_dr), 32'd3);
    chk("add_data", rb_wrData, 32'd8);
    chk("add_done", 32'(done), 32'd1);
    tick;
    chk("add_idle_ready", 32'(instr_ready), 32'd1);
    chk("add_idle_wr", 32'(rb_write), 32'd0);
    chk("add_result", result, 32'd8);
    tick;
    instr_valid = 1'b0;
    chk("ldi77_wr", 32'(rb_write), 32'd1);
    chk("ldi77_dr", 32'(rb_dr), 32'd0);
    chk("ldi77_data", rb_wrData, 32'h0000_0077);
    tick;
    chk("ldi77_result", result, 32'h0000_0077);

    alu_op("sub_r0", 2'd1, 2'd0, 2'd2, 2'd1, 32'hFFFF_FFFE);
`ifdef REGBANK_SEQ_FLAGS_EN
    chk("sub_flag_c", 32'(flag_c), 32'd1);
    chk("sub_flag_z", 32'(flag_z), 32'd0);
`endif

    ldi("ldi_msb", 2'd1, 32'h8000_0000);
`ifdef REGBANK_SEQ_FLAGS_EN
    chk("ldi_keeps_c", 32'(flag_c), 32'd1);
    chk("ldi_keeps_z", 32'(flag_z), 32'd0);
`endif
    alu_op("add_wrap", 2'd0, 2'd1, 2'd1, 2'd1, 32'h0000_0000);
`ifdef REGBANK_SEQ_FLAGS_EN
    chk("wrap_flag_z", 32'(flag_z), 32'd1);
    chk("wrap_flag_c", 32'(flag_c), 32'd1);
`endif
    // R1 must now read as zero: R3 = R1 + R0 = 0xFFFF_FFFE.
    alu_op("add_r1_chk", 2'd0, 2'd3, 2'd1, 2'd0, 32'hFFFF_FFFE);
`ifdef REGBANK_SEQ_FLAGS_EN
    chk("r1chk_flag_c", 32'(flag_c), 32'd0);
`endif
    alu_op("and_r2", 2'd2, 2'd2, 2'd3, 2'd2, 32'h0000_0002);
`ifdef REGBANK_SEQ_FLAGS_EN
    chk("and_flag_z", 32'(flag_z), 32'd0);
    chk("and_flag_c", 32'(flag_c), 32'd0);
`endif

    // Held valid: ADD R2,R2,R2 runs exactly three times (2 -> 4 -> 8 -> 16).
    done_seen = 0;
    ready_seen = 0;
    issue(2'd0, 2'd2, 2'd2, 2'd2, 32'd0);
    for (int i = 1; i <= 12; i++) begin
      tick;
      if (done) done_seen++;
      if (instr_ready) ready_seen++;
      chk("held_ready_phase", 32'(instr_ready), ((i % 4) == 0) ? 32'd1 : 32'd0);
      if (i == 11) instr_valid = 1'b0;
    end
    chk("held_done_count", 32'(done_seen), 32'd3);
    chk("held_ready_count", 32'(ready_seen), 32'd3);
    chk("held_result", result, 32'h0000_0010);

    // Reset during EXEC abandons ADD R0,R0,R0.
    issue(2'd0, 2'd0, 2'd0, 2'd0, 32'd0);
    tick;
    instr_valid = 1'b0;
    tick;
    #3 rst = 1'b1;
    #1;
    chk("midrst_ready", 32'(instr_ready), 32'd1);
    chk("midrst_write", 32'(rb_write), 32'd0);
    chk("midrst_result", result, 32'd0);
    chk("midrst_wrdata", rb_wrData, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick;
    chk("midrst_idle_write", 32'(rb_write), 32'd0);
    chk("midrst_r0_kept", mem[0], 32'hFFFF_FFFE);
    ldi("after_rst_ldi", 2'd1, 32'h0000_0009);
    chk("after_rst_r1", mem[1], 32'h0000_0009);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
